// File: rtl/layer_pkg.sv
// ---------------------------------------------------------------------------
// layer_pkg
// Shared types and constants for the layer sequencer:
//   - seq_state_e   : sequencer FSM states
//   - layer_entry_t : one layer-table entry {mask, repeat count, base flag}
//   - NUM_LAYERS_DEF / CNT_W_DEF : default table depth and counter width
// ---------------------------------------------------------------------------
package layer_pkg;

    localparam int NUM_LAYERS_DEF = 8;
    localparam int CNT_W_DEF      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_NEXT,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic [7:0]           mask;
        logic [CNT_W_DEF-1:0] cnt;
        logic                 base;
    } layer_entry_t;

endpackage

// File: rtl/layer_table.sv
// ---------------------------------------------------------------------------
// layer_table
// NUM_LAYERS-entry register file holding the per-layer configuration.
// One synchronous write port, one registered read port (data appears the
// cycle after rd_addr is presented).
// Ports:
//   io_clk, io_rst_n : clock, asynchronous active-low reset (clears table)
//   wr_en/wr_addr/wr_data : write port
//   rd_addr / rd_data     : registered read port
// ---------------------------------------------------------------------------
module layer_table
    import layer_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int AW         = 3
) (
    input  logic         io_clk,
    input  logic         io_rst_n,
    input  logic         wr_en,
    input  logic [AW-1:0] wr_addr,
    input  layer_entry_t wr_data,
    input  logic [AW-1:0] rd_addr,
    output layer_entry_t rd_data
);

    layer_entry_t mem_q [NUM_LAYERS];
    layer_entry_t mem_d [NUM_LAYERS];
    layer_entry_t rd_data_q, rd_data_d;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned; that is what keeps latches from inferring.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (int'(wr_addr) < NUM_LAYERS)) begin
            mem_d[wr_addr] = wr_data;
        end
        rd_data_d = '0;
        if (int'(rd_addr) < NUM_LAYERS) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // NOTE: the table is small and must read back as zero after reset, so it
    // is built from resettable flops rather than an unreset RAM macro.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            mem_q     <= '{default: '0};
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/layer_sequencer.sv
// ---------------------------------------------------------------------------
// layer_sequencer
// Steps through a programmable list of layers. For each layer it counts
// qualified switch events until the layer's repeat budget is used up, pulses
// io_layerEnd, and advances; after the last layer it optionally replays the
// whole list io_seqLoops more times, then pulses io_seqEnd.
// Ports:
//   io_clk, io_rst_n        : clock, asynchronous active-low reset
//   io_cfgWe/Addr/Mask/Cnt/Base : table write port (accepted in IDLE only)
//   io_numLayers, io_seqLoops   : sequence shape, sampled on io_start
//   io_start, io_abort          : control pulses
//   io_switchEnLogic            : per-switch event strobes
//   io_busy, io_layerIdx, io_layerCfg, io_layerCnt, io_repeatCnt : status
//   io_layerEnd, io_seqEnd      : one-cycle end strobes
//   io_cfgErr, io_missed        : sticky error flags, cleared on io_start
// ---------------------------------------------------------------------------
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int AW         = 3,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             io_clk,
    input  logic             io_rst_n,
    input  logic             io_cfgWe,
    input  logic [AW-1:0]    io_cfgAddr,
    input  logic [7:0]       io_cfgMask,
    input  logic [CNT_W-1:0] io_cfgCnt,
    input  logic             io_cfgBase,
    input  logic [AW:0]      io_numLayers,
    input  logic [CNT_W-1:0] io_seqLoops,
    input  logic             io_start,
    input  logic             io_abort,
    input  logic [7:0]       io_switchEnLogic,
    output logic             io_busy,
    output logic [AW-1:0]    io_layerIdx,
    output logic [7:0]       io_layerCfg,
    output logic [CNT_W-1:0] io_layerCnt,
    output logic [CNT_W-1:0] io_repeatCnt,
    output logic             io_layerEnd,
    output logic             io_seqEnd,
    output logic             io_cfgErr,
    output logic             io_missed
);

    seq_state_e       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      num_layers_q, num_layers_d;
    logic [CNT_W-1:0] seq_loops_q, seq_loops_d;
    logic [CNT_W-1:0] loop_q, loop_d;
    logic [7:0]       layer_cfg_q, layer_cfg_d;
    logic [CNT_W-1:0] layer_cnt_q, layer_cnt_d;
    logic             base_q, base_d;
    logic [CNT_W-1:0] repeat_q, repeat_d;
    logic             layer_end_q, layer_end_d;
    logic             seq_end_q, seq_end_d;
    logic             busy_q, busy_d;
    logic             cfg_err_q, cfg_err_d;
    logic             missed_q, missed_d;

    layer_entry_t     wr_entry;
    layer_entry_t     rd_entry;
    logic             tbl_we;

    logic             start_ok;
    logic             ev_hit;
    logic             ev_any;
    logic [CNT_W:0]   target;
    logic [CNT_W:0]   rep_inc;
    logic             completes;

    // ---------------------------------------------------------------------
    // Layer table. The read address is the *next* index, so the registered
    // read data lines up with the LOAD cycle that consumes it.
    // ---------------------------------------------------------------------
    assign tbl_we        = io_cfgWe && (state_q == ST_IDLE);
    assign wr_entry.mask = io_cfgMask;
    assign wr_entry.cnt  = CNT_W_DEF'(io_cfgCnt);
    assign wr_entry.base = io_cfgBase;

    layer_table #(
        .NUM_LAYERS (NUM_LAYERS),
        .AW         (AW)
    ) u_table (
        .io_clk   (io_clk),
        .io_rst_n (io_rst_n),
        .wr_en    (tbl_we),
        .wr_addr  (io_cfgAddr),
        .wr_data  (wr_entry),
        .rd_addr  (idx_d),
        .rd_data  (rd_entry)
    );

    // ---------------------------------------------------------------------
    // Event qualification and layer budget. The budget is computed one bit
    // wider than the counter so a non-base count of all-ones cannot wrap.
    // ---------------------------------------------------------------------
    assign start_ok = (io_numLayers != '0) &&
                      (io_numLayers <= (AW+1)'(NUM_LAYERS));
    assign ev_hit   = |(io_switchEnLogic & layer_cfg_q);
    assign ev_any   = |io_switchEnLogic;
    assign rep_inc  = {1'b0, repeat_q} + (CNT_W+1)'(1);

    always_comb begin
        if (layer_cnt_q == '0) begin
            target = (CNT_W+1)'(1);
        end else if (base_q) begin
            target = {1'b0, layer_cnt_q};
        end else begin
            target = {1'b0, layer_cnt_q} + (CNT_W+1)'(1);
        end
    end

    assign completes = (rep_inc == target);

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: combinational next-state code uses blocking '=' so later lines
    // see earlier updates (e.g. the abort override below); the flops take
    // these values with non-blocking '<=' only.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        num_layers_d = num_layers_q;
        seq_loops_d  = seq_loops_q;
        loop_d       = loop_q;
        layer_cfg_d  = layer_cfg_q;
        layer_cnt_d  = layer_cnt_q;
        base_d       = base_q;
        repeat_d     = repeat_q;
        layer_end_d  = 1'b0;
        cfg_err_d    = cfg_err_q;
        missed_d     = missed_q;

        unique case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    if (start_ok) begin
                        state_d      = ST_LOAD;
                        num_layers_d = io_numLayers;
                        seq_loops_d  = io_seqLoops;
                        loop_d       = '0;
                        idx_d        = '0;
                        cfg_err_d    = 1'b0;
                        missed_d     = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                layer_cfg_d = rd_entry.mask;
                layer_cnt_d = CNT_W'(rd_entry.cnt);
                base_d      = rd_entry.base;
                repeat_d    = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (ev_hit) begin
                    if (completes) begin
                        repeat_d    = '0;
                        layer_end_d = 1'b1;
                        state_d     = ST_NEXT;
                    end else begin
                        repeat_d = rep_inc[CNT_W-1:0];
                    end
                end
            end
            ST_NEXT: begin
                if (({1'b0, idx_q} + (AW+1)'(1)) < num_layers_q) begin
                    idx_d   = idx_q + AW'(1);
                    state_d = ST_LOAD;
                end else if (loop_q < seq_loops_q) begin
                    loop_d  = loop_q + CNT_W'(1);
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the busy state decided, including a
        // completing event in the same cycle; the counter and index freeze.
        if (io_abort && (state_q inside {ST_LOAD, ST_RUN, ST_NEXT})) begin
            state_d     = ST_DONE;
            layer_end_d = 1'b0;
            repeat_d    = repeat_q;
            idx_d       = idx_q;
            loop_d      = loop_q;
        end

        // Strobes outside RUN are dropped but remembered.
        if (ev_any && (state_q inside {ST_LOAD, ST_NEXT, ST_DONE})) begin
            missed_d = 1'b1;
        end

        // Table writes are only honoured in IDLE.
        if (io_cfgWe && (state_q != ST_IDLE)) begin
            cfg_err_d = 1'b1;
        end
    end

    assign busy_d    = (state_d != ST_IDLE);
    assign seq_end_d = (state_d == ST_DONE);

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            num_layers_q <= '0;
            seq_loops_q  <= '0;
            loop_q       <= '0;
            layer_cfg_q  <= '0;
            layer_cnt_q  <= '0;
            base_q       <= 1'b0;
            repeat_q     <= '0;
            layer_end_q  <= 1'b0;
            seq_end_q    <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            missed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            num_layers_q <= num_layers_d;
            seq_loops_q  <= seq_loops_d;
            loop_q       <= loop_d;
            layer_cfg_q  <= layer_cfg_d;
            layer_cnt_q  <= layer_cnt_d;
            base_q       <= base_d;
            repeat_q     <= repeat_d;
            layer_end_q  <= layer_end_d;
            seq_end_q    <= seq_end_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            missed_q     <= missed_d;
        end
    end

    assign io_busy      = busy_q;
    assign io_layerIdx  = idx_q;
    assign io_layerCfg  = layer_cfg_q;
    assign io_layerCnt  = layer_cnt_q;
    assign io_repeatCnt = repeat_q;
    assign io_layerEnd  = layer_end_q;
    assign io_seqEnd    = seq_end_q;
    assign io_cfgErr    = cfg_err_q;
    assign io_missed    = missed_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_layer_sequencer
// Directed bench for layer_sequencer. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge in between.
// ---------------------------------------------------------------------------
module tb_layer_sequencer;

    localparam int AW    = 3;
    localparam int CNT_W = 16;

    logic             io_clk;
    logic             io_rst_n;
    logic             io_cfgWe;
    logic [AW-1:0]    io_cfgAddr;
    logic [7:0]       io_cfgMask;
    logic [CNT_W-1:0] io_cfgCnt;
    logic             io_cfgBase;
    logic [AW:0]      io_numLayers;
    logic [CNT_W-1:0] io_seqLoops;
    logic             io_start;
    logic             io_abort;
    logic [7:0]       io_switchEnLogic;
    logic             io_busy;
    logic [AW-1:0]    io_layerIdx;
    logic [7:0]       io_layerCfg;
    logic [CNT_W-1:0] io_layerCnt;
    logic [CNT_W-1:0] io_repeatCnt;
    logic             io_layerEnd;
    logic             io_seqEnd;
    logic             io_cfgErr;
    logic             io_missed;

    int n_checks = 0;
    int n_pass   = 0;
    int le_cnt   = 0;
    int se_cnt   = 0;
    int le0, se0;

    layer_sequencer #(.NUM_LAYERS(8), .AW(AW), .CNT_W(CNT_W)) dut (
        .io_clk           (io_clk),
        .io_rst_n         (io_rst_n),
        .io_cfgWe         (io_cfgWe),
        .io_cfgAddr       (io_cfgAddr),
        .io_cfgMask       (io_cfgMask),
        .io_cfgCnt        (io_cfgCnt),
        .io_cfgBase       (io_cfgBase),
        .io_numLayers     (io_numLayers),
        .io_seqLoops      (io_seqLoops),
        .io_start         (io_start),
        .io_abort         (io_abort),
        .io_switchEnLogic (io_switchEnLogic),
        .io_busy          (io_busy),
        .io_layerIdx      (io_layerIdx),
        .io_layerCfg      (io_layerCfg),
        .io_layerCnt      (io_layerCnt),
        .io_repeatCnt     (io_repeatCnt),
        .io_layerEnd      (io_layerEnd),
        .io_seqEnd        (io_seqEnd),
        .io_cfgErr        (io_cfgErr),
        .io_missed        (io_missed)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    // Pulse counters for the looping test.
    always @(negedge io_clk) begin
        if (io_layerEnd) le_cnt = le_cnt + 1;
        if (io_seqEnd)   se_cnt = se_cnt + 1;
    end

    // Hard time limit in case the sequencer never returns.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, n_pass=%0d", n_pass);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        assert (obs === exp_v) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic cyc();
        @(negedge io_clk);
    endtask

    task automatic write_entry(input logic [AW-1:0] a, input logic [7:0] m,
                               input logic [CNT_W-1:0] c, input logic b);
        io_cfgWe = 1'b1; io_cfgAddr = a; io_cfgMask = m; io_cfgCnt = c; io_cfgBase = b;
        cyc();
        io_cfgWe = 1'b0;
    endtask

    task automatic pulse_ev(input logic [7:0] bits);
        io_switchEnLogic = bits;
        cyc();
        io_switchEnLogic = '0;
    endtask

    task automatic start_seq(input logic [AW:0] nl, input logic [CNT_W-1:0] loops);
        io_numLayers = nl; io_seqLoops = loops; io_start = 1'b1;
        cyc();
        io_start = 1'b0;
    endtask

    // Runs one layer already in RUN: nev events on 'bits', one every 4 cycles.
    // Ends on the cycle that shows io_layerEnd.
    task automatic run_layer(input int exp_idx, input int nev, input logic [7:0] bits);
        check($sformatf("layer_idx_%0d", exp_idx), 32'(io_layerIdx), 32'(exp_idx));
        for (int i = 0; i < nev; i++) begin
            pulse_ev(bits);
            if (i < nev - 1) begin
                check("repeat_cnt_step", 32'(io_repeatCnt), 32'(i + 1));
                check("no_early_layer_end", 32'(io_layerEnd), 32'd0);
                cyc(); cyc(); cyc();
            end
        end
        check("layer_end_pulse", 32'(io_layerEnd), 32'd1);
        check("repeat_cnt_cleared", 32'(io_repeatCnt), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(io_busy),      32'd0);
        check({tag, "_idx"},    32'(io_layerIdx),  32'd0);
        check({tag, "_cfg"},    32'(io_layerCfg),  32'd0);
        check({tag, "_cnt"},    32'(io_layerCnt),  32'd0);
        check({tag, "_rep"},    32'(io_repeatCnt), 32'd0);
        check({tag, "_lend"},   32'(io_layerEnd),  32'd0);
        check({tag, "_send"},   32'(io_seqEnd),    32'd0);
        check({tag, "_cfgerr"}, 32'(io_cfgErr),    32'd0);
        check({tag, "_missed"}, 32'(io_missed),    32'd0);
    endtask

    initial begin
        io_rst_n = 1'b0; io_cfgWe = 1'b0; io_cfgAddr = '0; io_cfgMask = '0;
        io_cfgCnt = '0; io_cfgBase = 1'b0; io_numLayers = '0; io_seqLoops = '0;
        io_start = 1'b0; io_abort = 1'b0; io_switchEnLogic = '0;

        // ---------------- reset state ----------------
        cyc(); cyc();
        check_all_zero("reset");
        io_rst_n = 1'b1;
        cyc();

        // ---------------- two-layer single pass ----------------
        write_entry(3'd0, 8'h01, 16'd3, 1'b1);
        write_entry(3'd1, 8'h02, 16'd2, 1'b0);
        start_seq(4'd2, 16'd0);
        check("load_busy", 32'(io_busy), 32'd1);
        check("load_idx0", 32'(io_layerIdx), 32'd0);
        cyc();
        check("l0_cfg", 32'(io_layerCfg), 32'h01);
        check("l0_cnt", 32'(io_layerCnt), 32'd3);
        check("l0_rep0", 32'(io_repeatCnt), 32'd0);
        pulse_ev(8'h80);
        check("unmasked_ignored", 32'(io_repeatCnt), 32'd0);
        cyc(); cyc(); cyc();
        run_layer(0, 3, 8'h01);
        cyc();
        check("next_lend_drop", 32'(io_layerEnd), 32'd0);
        cyc();
        check("l1_cfg", 32'(io_layerCfg), 32'h02);
        check("l1_cnt", 32'(io_layerCnt), 32'd2);
        pulse_ev(8'h01);
        check("l1_wrong_bit", 32'(io_repeatCnt), 32'd0);
        cyc(); cyc(); cyc();
        run_layer(1, 3, 8'h02);
        cyc();
        check("done_seq_end", 32'(io_seqEnd), 32'd1);
        check("done_busy", 32'(io_busy), 32'd1);
        cyc();
        check("idle_busy", 32'(io_busy), 32'd0);
        check("idle_seq_end", 32'(io_seqEnd), 32'd0);
        check("idle_missed", 32'(io_missed), 32'd0);

        // ---------------- replayed sequence (seqLoops=2) ----------------
        le0 = le_cnt; se0 = se_cnt;
        start_seq(4'd2, 16'd2);
        cyc();
        for (int p = 0; p < 3; p++) begin
            for (int l = 0; l < 2; l++) begin
                run_layer(l, 3, (l == 0) ? 8'h01 : 8'h02);
                if (!(p == 2 && l == 1)) begin
                    cyc(); cyc();
                end
            end
        end
        cyc();
        check("loop_seq_end", 32'(io_seqEnd), 32'd1);
        cyc();
        check("loop_layer_ends", 32'(le_cnt - le0), 32'd6);
        check("loop_seq_ends", 32'(se_cnt - se0), 32'd1);
        check("loop_idle", 32'(io_busy), 32'd0);

        // ---------------- cnt=0, any bit ends layer ----------------
        write_entry(3'd0, 8'hFF, 16'd0, 1'b0);
        start_seq(4'd1, 16'd0);
        cyc();
        check("c0_cnt", 32'(io_layerCnt), 32'd0);
        pulse_ev(8'h40);
        check("c0_layer_end", 32'(io_layerEnd), 32'd1);
        cyc();
        check("c0_seq_end", 32'(io_seqEnd), 32'd1);
        cyc();
        check("c0_idle", 32'(io_busy), 32'd0);

        // ---------------- missed event, write in RUN, abort ----------------
        write_entry(3'd0, 8'h01, 16'd3, 1'b1);
        start_seq(4'd1, 16'd0);
        io_switchEnLogic = 8'h01;   // lands in the LOAD cycle
        cyc();
        io_switchEnLogic = '0;
        check("load_ev_missed", 32'(io_missed), 32'd1);
        check("load_ev_not_counted", 32'(io_repeatCnt), 32'd0);
        write_entry(3'd0, 8'h55, 16'd7, 1'b0);
        check("run_write_cfg_err", 32'(io_cfgErr), 32'd1);
        pulse_ev(8'h01);
        pulse_ev(8'h01);
        check("pre_abort_rep", 32'(io_repeatCnt), 32'd2);
        io_switchEnLogic = 8'h01; io_abort = 1'b1;
        cyc();
        io_switchEnLogic = '0; io_abort = 1'b0;
        check("abort_no_layer_end", 32'(io_layerEnd), 32'd0);
        check("abort_seq_end", 32'(io_seqEnd), 32'd1);
        cyc();
        check("abort_idle", 32'(io_busy), 32'd0);
        start_seq(4'd1, 16'd0);
        check("start_clears_cfg_err", 32'(io_cfgErr), 32'd0);
        check("start_clears_missed", 32'(io_missed), 32'd0);
        cyc();
        check("table_unchanged_mask", 32'(io_layerCfg), 32'h01);
        check("table_unchanged_cnt", 32'(io_layerCnt), 32'd3);
        io_abort = 1'b1;
        cyc();
        io_abort = 1'b0;
        check("abort2_seq_end", 32'(io_seqEnd), 32'd1);
        cyc();

        // ---------------- bad numLayers ----------------
        start_seq(4'd0, 16'd0);
        check("nl0_idle", 32'(io_busy), 32'd0);
        check("nl0_cfg_err", 32'(io_cfgErr), 32'd1);
        start_seq(4'd9, 16'd0);
        check("nl9_idle", 32'(io_busy), 32'd0);

        // ---------------- async reset mid-RUN ----------------
        start_seq(4'd1, 16'd0);
        cyc();
        pulse_ev(8'h01);
        write_entry(3'd2, 8'hAA, 16'd1, 1'b1);
        check("mid_rep", 32'(io_repeatCnt), 32'd1);
        check("mid_cfg_err", 32'(io_cfgErr), 32'd1);
        #2;
        io_rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        cyc();
        io_rst_n = 1'b1;
        cyc();
        start_seq(4'd1, 16'd0);
        cyc();
        check("cleared_tbl_mask", 32'(io_layerCfg), 32'h00);
        check("cleared_tbl_cnt", 32'(io_layerCnt), 32'd0);
        io_abort = 1'b1;
        cyc();
        io_abort = 1'b0;
        cyc();
        check("final_idle", 32'(io_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
